// File: rtl/recarga_pkg.sv
// Shared types and constants for the recharge kiosk and its 7-segment display.
package recarga_pkg;

  // Controller states. Encodings are fixed so waveforms read the same across builds.
  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    COLETANDO = 3'd1,
    ENVIANDO  = 3'd2,
    INTERVALO = 3'd3,
    ERRO      = 3'd4
  } estado_t;

  // Pass ceiling: the most credit one transaction may carry.
  localparam int MAX_CREDITO_PADRAO = 5;

  // Cycles a chunk may wait for rec_ack before the link is declared dead.
  localparam int TIMEOUT_PADRAO = 15;

  // Largest chunk the turnstile accepts in one handshake.
  localparam logic [1:0] QTD_MAX = 2'd3;

  // Segment patterns, bit 6 = g ... bit 0 = a, active high.
  localparam logic [6:0] DIG0        = 7'b0111111;
  localparam logic [6:0] DIG1        = 7'b0000110;
  localparam logic [6:0] DIG2        = 7'b1011011;
  localparam logic [6:0] DIG3        = 7'b1001111;
  localparam logic [6:0] DIG4        = 7'b1100110;
  localparam logic [6:0] DIG5        = 7'b1101101;
  localparam logic [6:0] DIG_APAGADO = 7'b0000000;

  // Size of the next chunk: whatever is left, capped at QTD_MAX.
  function automatic logic [1:0] qtd_chunk(input logic [2:0] credito);
    if (credito >= {1'b0, QTD_MAX}) begin
      return QTD_MAX;
    end
    return credito[1:0];
  endfunction

endpackage

// File: rtl/recarga_quiosque_dec7seg.sv
// Combinational 3-bit to 7-segment decoder. Shows 0..5; anything else is blank,
// so the turnstile display can reuse it unchanged.
module dec7seg
  import recarga_pkg::*;
(
  input  logic [2:0] i_valor,
  output logic [6:0] o_seg
);

  // Map the credit value onto its segment pattern.
  always_comb begin
    unique case (i_valor)
      3'd0:    o_seg = DIG0;
      3'd1:    o_seg = DIG1;
      3'd2:    o_seg = DIG2;
      3'd3:    o_seg = DIG3;
      3'd4:    o_seg = DIG4;
      3'd5:    o_seg = DIG5;
      default: o_seg = DIG_APAGADO;
    endcase
  end

endmodule

// File: rtl/recarga_quiosque.sv
// Recharge kiosk: collects coins, then pushes the credit to the turnstile in
// chunks of at most QTD_MAX over a valid/ack link, with refund and timeout handling.
module recarga_quiosque
  import recarga_pkg::*;
#(
  parameter int MAX_CREDITO = MAX_CREDITO_PADRAO,
  parameter int TIMEOUT     = TIMEOUT_PADRAO
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       moeda,
  input  logic [1:0] valor_moeda,
  input  logic       sel_passe,
  input  logic       confirma,
  input  logic       cancela,
  output logic       rec_valid,
  output logic       rec_passe,
  output logic [1:0] rec_qtd,
  input  logic       rec_ack,
  output logic [2:0] credito,
  output logic       devolve,
  output logic       estorno_valid,
  output logic [2:0] estorno_qtd,
  output logic       concluido,
  output logic       erro,
  output logic [6:0] seg
);

  estado_t    r_estado;
  logic [2:0] r_credito;
  logic [3:0] r_cnt;
  logic       r_rec_valid;
  logic       r_rec_passe;
  logic [1:0] r_rec_qtd;
  logic       r_devolve;
  logic       r_estorno_valid;
  logic [2:0] r_estorno_qtd;
  logic       r_concluido;

  logic [3:0] w_soma;
  logic       w_moeda_cabe;
  logic       w_aceita;
  logic [2:0] w_resto;
  logic [1:0] w_qtd_nova;
  logic       w_expirou;

  // Coin acceptance and chunk arithmetic, shared by the state register below.
  always_comb begin
    // NOTE: every signal gets a value before any branch so no latch is inferred.
    w_aceita     = 1'b0;
    // Four bits wide so credit + coin can never wrap back under the ceiling.
    w_soma       = {1'b0, r_credito} + {2'b00, valor_moeda};
    w_moeda_cabe = moeda && (valor_moeda != 2'd0) && (w_soma <= 4'(MAX_CREDITO));
    w_resto      = r_credito - {1'b0, r_rec_qtd};
    w_qtd_nova   = qtd_chunk(r_credito);
    w_expirou    = (r_cnt == 4'(TIMEOUT - 1));
    unique case (r_estado)
      OCIOSO:    w_aceita = w_moeda_cabe;
      // Cancel and confirm both pre-empt a coin arriving in the same cycle.
      COLETANDO: w_aceita = w_moeda_cabe && !cancela &&
                            !(confirma && (r_credito != 3'd0));
      default:   w_aceita = 1'b0;
    endcase
  end

  // Controller state, credit and all registered outputs.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_estado        <= OCIOSO;
      r_credito       <= 3'd0;
      r_cnt           <= 4'd0;
      r_rec_valid     <= 1'b0;
      r_rec_passe     <= 1'b0;
      r_rec_qtd       <= 2'd0;
      r_devolve       <= 1'b0;
      r_estorno_valid <= 1'b0;
      r_estorno_qtd   <= 3'd0;
      r_concluido     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      // Pulses default low; any coin not accepted this cycle is handed back.
      r_devolve       <= moeda && !w_aceita;
      r_estorno_valid <= 1'b0;
      r_estorno_qtd   <= 3'd0;
      r_concluido     <= 1'b0;

      unique case (r_estado)
        OCIOSO: begin
          if (w_aceita) begin
            r_credito <= w_soma[2:0];
            r_estado  <= COLETANDO;
          end
        end

        COLETANDO: begin
          if (cancela) begin
            r_estorno_valid <= 1'b1;
            r_estorno_qtd   <= r_credito;
            r_credito       <= 3'd0;
            r_estado        <= OCIOSO;
          end else if (confirma && (r_credito != 3'd0)) begin
            r_rec_passe <= sel_passe;
            r_rec_qtd   <= w_qtd_nova;
            r_rec_valid <= 1'b1;
            r_cnt       <= 4'd0;
            r_estado    <= ENVIANDO;
          end else if (w_aceita) begin
            r_credito <= w_soma[2:0];
          end
        end

        // Request held stable until ack or timeout; cancel cannot break a transfer.
        ENVIANDO: begin
          if (rec_ack) begin
            r_credito   <= w_resto;
            r_rec_valid <= 1'b0;
            r_rec_qtd   <= 2'd0;
            if (w_resto == 3'd0) begin
              r_concluido <= 1'b1;
              r_estado    <= OCIOSO;
            end else begin
              r_estado <= INTERVALO;
            end
          end else if (w_expirou) begin
            r_rec_valid <= 1'b0;
            r_rec_qtd   <= 2'd0;
            r_estado    <= ERRO;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        // One idle cycle between chunks, then the next chunk with a fresh timeout.
        INTERVALO: begin
          r_rec_valid <= 1'b1;
          r_rec_qtd   <= w_qtd_nova;
          r_cnt       <= 4'd0;
          r_estado    <= ENVIANDO;
        end

        // Credit is kept so the user can get it back with cancela.
        ERRO: begin
          if (cancela) begin
            r_estorno_valid <= 1'b1;
            r_estorno_qtd   <= r_credito;
            r_credito       <= 3'd0;
            r_estado        <= OCIOSO;
          end
        end

        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign rec_valid     = r_rec_valid;
  assign rec_passe     = r_rec_passe;
  assign rec_qtd       = r_rec_qtd;
  assign credito       = r_credito;
  assign devolve       = r_devolve;
  assign estorno_valid = r_estorno_valid;
  assign estorno_qtd   = r_estorno_qtd;
  assign concluido     = r_concluido;
  assign erro          = (r_estado == ERRO);

  dec7seg u_dec7seg (
    .i_valor (r_credito),
    .o_seg   (seg)
  );

endmodule

// File: tb/tb_recarga_quiosque.sv
// Directed bench for the recharge kiosk: coin handling, chunked transfer,
// link timeout, refunds and asynchronous reset.
module tb_recarga_quiosque;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       moeda;
  logic [1:0] valor_moeda;
  logic       sel_passe;
  logic       confirma;
  logic       cancela;
  logic       rec_valid;
  logic       rec_passe;
  logic [1:0] rec_qtd;
  logic       rec_ack;
  logic [2:0] credito;
  logic       devolve;
  logic       estorno_valid;
  logic [2:0] estorno_qtd;
  logic       concluido;
  logic       erro;
  logic [6:0] seg;

  int n_cmp  = 0;
  int n_fail = 0;

  recarga_quiosque dut (
    .clk_2         (clk_2),
    .reset         (reset),
    .moeda         (moeda),
    .valor_moeda   (valor_moeda),
    .sel_passe     (sel_passe),
    .confirma      (confirma),
    .cancela       (cancela),
    .rec_valid     (rec_valid),
    .rec_passe     (rec_passe),
    .rec_qtd       (rec_qtd),
    .rec_ack       (rec_ack),
    .credito       (credito),
    .devolve       (devolve),
    .estorno_valid (estorno_valid),
    .estorno_qtd   (estorno_qtd),
    .concluido     (concluido),
    .erro          (erro),
    .seg           (seg)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling or driving.
  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic idle_inputs();
    moeda       = 1'b0;
    valor_moeda = 2'd0;
    confirma    = 1'b0;
    cancela     = 1'b0;
    rec_ack     = 1'b0;
  endtask

  task automatic coin(input logic [1:0] v);
    moeda       = 1'b1;
    valor_moeda = v;
    step();
    moeda       = 1'b0;
    valor_moeda = 2'd0;
  endtask

  initial begin
    reset     = 1'b1;
    sel_passe = 1'b0;
    idle_inputs();
    step();
    step();
    check("rst_credito", 8'(credito), 8'd0);
    check("rst_seg", 8'(seg), 8'b0111111);
    check("rst_valid", 8'(rec_valid), 8'd0);
    check("rst_passe", 8'(rec_passe), 8'd0);
    check("rst_qtd", 8'(rec_qtd), 8'd0);
    check("rst_pulses", 8'({devolve, estorno_valid, concluido, erro}), 8'd0);
    reset = 1'b0;
    step();

    // Coins 2, 2 accepted; third 2 would overflow 5 and is returned.
    coin(2'd2);
    check("c1_credito", 8'(credito), 8'd2);
    check("c1_seg", 8'(seg), 8'b1011011);
    check("c1_devolve", 8'(devolve), 8'd0);
    coin(2'd2);
    check("c2_credito", 8'(credito), 8'd4);
    coin(2'd2);
    check("c3_devolve", 8'(devolve), 8'd1);
    check("c3_credito", 8'(credito), 8'd4);
    check("c3_seg", 8'(seg), 8'b1100110);
    step();
    check("c3_devolve_end", 8'(devolve), 8'd0);
    // Invalid coin value 0 is returned too.
    coin(2'd0);
    check("c0_devolve", 8'(devolve), 8'd1);
    check("c0_credito", 8'(credito), 8'd4);
    // Exactly reaching the ceiling is allowed.
    coin(2'd1);
    check("c4_credito", 8'(credito), 8'd5);
    check("c4_seg", 8'(seg), 8'b1101101);

    // Transfer 5 to pass 2: chunk 3, idle cycle, chunk 2.
    sel_passe = 1'b1;
    confirma  = 1'b1;
    step();
    confirma  = 1'b0;
    sel_passe = 1'b0;
    check("t1_valid", 8'(rec_valid), 8'd1);
    check("t1_passe", 8'(rec_passe), 8'd1);
    check("t1_qtd", 8'(rec_qtd), 8'd3);
    step();
    check("t1_hold_valid", 8'(rec_valid), 8'd1);
    check("t1_hold_qtd", 8'(rec_qtd), 8'd3);
    rec_ack = 1'b1;
    step();
    rec_ack = 1'b0;
    check("t1_gap_valid", 8'(rec_valid), 8'd0);
    check("t1_gap_credito", 8'(credito), 8'd2);
    check("t1_gap_concl", 8'(concluido), 8'd0);
    step();
    check("t2_valid", 8'(rec_valid), 8'd1);
    check("t2_qtd", 8'(rec_qtd), 8'd2);
    check("t2_passe", 8'(rec_passe), 8'd1);
    rec_ack = 1'b1;
    step();
    rec_ack = 1'b0;
    check("t2_concl", 8'(concluido), 8'd1);
    check("t2_credito", 8'(credito), 8'd0);
    check("t2_valid_off", 8'(rec_valid), 8'd0);
    check("t2_seg", 8'(seg), 8'b0111111);
    step();
    check("t2_concl_end", 8'(concluido), 8'd0);
    // Idle: confirma and cancela do nothing.
    confirma = 1'b1;
    cancela  = 1'b1;
    step();
    idle_inputs();
    check("idle_valid", 8'(rec_valid), 8'd0);
    check("idle_estorno", 8'(estorno_valid), 8'd0);

    // Credit 3, no ack: 15 cycles of valid, then error with credit retained.
    coin(2'd2);
    coin(2'd1);
    check("to_credito", 8'(credito), 8'd3);
    confirma = 1'b1;
    step();
    confirma = 1'b0;
    check("to_valid0", 8'(rec_valid), 8'd1);
    check("to_passe", 8'(rec_passe), 8'd0);
    check("to_qtd", 8'(rec_qtd), 8'd3);
    for (int i = 0; i < 14; i++) begin
      step();
      check("to_wait_valid", 8'(rec_valid), 8'd1);
    end
    check("to_wait_erro", 8'(erro), 8'd0);
    step();
    check("to_valid_off", 8'(rec_valid), 8'd0);
    check("to_erro", 8'(erro), 8'd1);
    check("to_credito_kept", 8'(credito), 8'd3);
    // Late ack, coin and confirm are all ignored in ERRO (coin returned).
    rec_ack     = 1'b1;
    confirma    = 1'b1;
    moeda       = 1'b1;
    valor_moeda = 2'd1;
    step();
    idle_inputs();
    check("er_devolve", 8'(devolve), 8'd1);
    check("er_credito", 8'(credito), 8'd3);
    check("er_valid", 8'(rec_valid), 8'd0);
    check("er_erro", 8'(erro), 8'd1);
    cancela = 1'b1;
    step();
    cancela = 1'b0;
    check("er_estorno_v", 8'(estorno_valid), 8'd1);
    check("er_estorno_q", 8'(estorno_qtd), 8'd3);
    check("er_erro_clr", 8'(erro), 8'd0);
    check("er_credito_clr", 8'(credito), 8'd0);
    step();
    check("er_estorno_end", 8'(estorno_valid), 8'd0);

    // Cancel beats a coin in the same cycle.
    coin(2'd2);
    coin(2'd2);
    check("cc_credito", 8'(credito), 8'd4);
    cancela     = 1'b1;
    moeda       = 1'b1;
    valor_moeda = 2'd1;
    step();
    idle_inputs();
    check("cc_estorno_v", 8'(estorno_valid), 8'd1);
    check("cc_estorno_q", 8'(estorno_qtd), 8'd4);
    check("cc_devolve", 8'(devolve), 8'd1);
    check("cc_credito", 8'(credito), 8'd0);

    // Coin and cancel during ENVIANDO: coin returned, transfer still completes.
    coin(2'd2);
    confirma = 1'b1;
    step();
    confirma = 1'b0;
    check("en_valid", 8'(rec_valid), 8'd1);
    check("en_qtd", 8'(rec_qtd), 8'd2);
    cancela     = 1'b1;
    moeda       = 1'b1;
    valor_moeda = 2'd1;
    step();
    idle_inputs();
    check("en_devolve", 8'(devolve), 8'd1);
    check("en_no_estorno", 8'(estorno_valid), 8'd0);
    check("en_still_valid", 8'(rec_valid), 8'd1);
    check("en_credito", 8'(credito), 8'd2);
    rec_ack = 1'b1;
    step();
    rec_ack = 1'b0;
    check("en_concl", 8'(concluido), 8'd1);
    check("en_credito_end", 8'(credito), 8'd0);

    // Coin of 3 on top of 3 overflows and is returned.
    coin(2'd3);
    coin(2'd3);
    check("ov_devolve", 8'(devolve), 8'd1);
    check("ov_credito", 8'(credito), 8'd3);

    // Asynchronous reset in the middle of a transfer.
    confirma = 1'b1;
    step();
    confirma = 1'b0;
    check("ar_valid_before", 8'(rec_valid), 8'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", 8'(rec_valid), 8'd0);
    check("ar_credito", 8'(credito), 8'd0);
    check("ar_seg", 8'(seg), 8'b0111111);
    check("ar_erro", 8'(erro), 8'd0);
    step();
    reset = 1'b0;
    step();
    // Back in OCIOSO: a coin is accepted and no request is raised.
    coin(2'd1);
    check("ar_coin_credito", 8'(credito), 8'd1);
    check("ar_coin_valid", 8'(rec_valid), 8'd0);
    check("ar_seg1", 8'(seg), 8'b0000110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
